// File: rtl/vga_plot_pkg.sv
// Shared definitions for the VGA pixel-write path: default coordinate/colour
// widths, screen geometry and the plot arbiter state encoding.
package vga_plot_pkg;

  localparam int unsigned DEF_X_W      = 8;
  localparam int unsigned DEF_Y_W      = 7;
  localparam int unsigned DEF_COL_W    = 3;
  localparam int unsigned DEF_SCREEN_W = 160;
  localparam int unsigned DEF_SCREEN_H = 120;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_CLEAR = 2'd2
  } plot_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at or
// after the pointer (wrapping) as a one-hot vector, plus an any-request flag.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          any
);

  logic found;

  // Scan positions ptr, ptr+1, ... and take the first requester seen
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (!found && req[j] && (j == ((32'(ptr) + k) % N))) begin
          winner[j] = 1'b1;
          found     = 1'b1;
        end
      end
    end
    any = |req;
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing the VGA adapter pixel-write port among NUM_REQ
// shape drawers. A grant is held for one shape or MAX_BURST pixels; accepted
// pixels appear on x/y/colour/plot one cycle later.
// Optional full-screen clear sweep is built when VGA_PLOT_CLEAR_EN is defined.
module vga_plot_arbiter
  import vga_plot_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned X_W       = DEF_X_W,
  parameter int unsigned Y_W       = DEF_Y_W,
  parameter int unsigned COL_W     = DEF_COL_W,
  parameter int unsigned MAX_BURST = 64,
  parameter int unsigned SCREEN_W  = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H  = DEF_SCREEN_H
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       last,
  input  logic [NUM_REQ*X_W-1:0]   x_in,
  input  logic [NUM_REQ*Y_W-1:0]   y_in,
  input  logic [NUM_REQ*COL_W-1:0] col_in,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_REQ-1:0]       grant,
  output logic [X_W-1:0]           x,
  output logic [Y_W-1:0]           y,
  output logic [COL_W-1:0]         colour,
  output logic                     plot,
  output logic                     busy,
  input  logic                     clear_req,
  input  logic [COL_W-1:0]         clear_colour,
  output logic                     clear_done
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  plot_state_t          state;
  logic [NUM_REQ-1:0]   win;
  logic                 win_any;
  logic [PTR_W-1:0]     ptr, gidx, win_idx, nxt_ptr;
  logic [7:0]           cnt;
  logic                 ack_any, req_g, last_g, burst_end;
  logic [X_W-1:0]       sel_x;
  logic [Y_W-1:0]       sel_y;
  logic [COL_W-1:0]     sel_c;

`ifdef VGA_PLOT_CLEAR_EN
  localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);
  logic                 clr_pend, clr_last;
  logic [X_W-1:0]       cx;
  logic [Y_W-1:0]       cy;
  logic [COL_W-1:0]     clr_col;
`else
  logic unused_clear;
  assign unused_clear = ^{clear_req, clear_colour};
  assign clear_done   = 1'b0;
`endif

  rr_pick #(.N(NUM_REQ), .PW(PTR_W)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (win),
    .any    (win_any)
  );

  // Index of the picker winner, stored with the grant to advance the pointer
  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win[i]) win_idx = PTR_W'(i);
    end
  end

  // Handshake, owner pixel mux and burst termination
  always_comb begin
    ack     = (state == ST_BURST) ? (req & grant) : '0;
    ack_any = |ack;
    req_g   = |(req & grant);
    last_g  = |(last & grant);
    sel_x   = '0;
    sel_y   = '0;
    sel_c   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_x = x_in[i*X_W +: X_W];
        sel_y = y_in[i*Y_W +: Y_W];
        sel_c = col_in[i*COL_W +: COL_W];
      end
    end
    nxt_ptr   = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    burst_end = !req_g || (ack_any && (last_g || (cnt == 8'(MAX_BURST - 1))));
  end

  // busy also covers the cycle in which the final accepted pixel is still on the port
  assign busy = (state != ST_IDLE) | plot;

  // Arbiter FSM with registered grant and adapter-port outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      grant  <= '0;
      gidx   <= '0;
      ptr    <= '0;
      cnt    <= '0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
`ifdef VGA_PLOT_CLEAR_EN
      clr_pend   <= 1'b0;
      clr_last   <= 1'b0;
      clear_done <= 1'b0;
      cx         <= '0;
      cy         <= '0;
      clr_col    <= '0;
`endif
    end else begin
      plot <= 1'b0;
`ifdef VGA_PLOT_CLEAR_EN
      clr_last   <= 1'b0;
      clear_done <= clr_last;
      if (clear_req && (state != ST_CLEAR)) clr_pend <= 1'b1;
`endif
      case (state)
        ST_IDLE: begin
`ifdef VGA_PLOT_CLEAR_EN
          if (clr_pend) begin
            state    <= ST_CLEAR;
            clr_pend <= 1'b0;
            clr_col  <= clear_colour;
            cx       <= '0;
            cy       <= '0;
          end else
`endif
          if (win_any) begin
            grant <= win;
            gidx  <= win_idx;
            cnt   <= '0;
            state <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (ack_any) begin
            x      <= sel_x;
            y      <= sel_y;
            colour <= sel_c;
            plot   <= 1'b1;
            cnt    <= cnt + 8'd1;
          end
          if (burst_end) begin
            state <= ST_IDLE;
            grant <= '0;
            ptr   <= nxt_ptr;
          end
        end
`ifdef VGA_PLOT_CLEAR_EN
        ST_CLEAR: begin
          x      <= cx;
          y      <= cy;
          colour <= clr_col;
          plot   <= 1'b1;
          if (cx == X_LAST) begin
            cx <= '0;
            if (cy == Y_LAST) begin
              cy       <= '0;
              state    <= ST_IDLE;
              clr_last <= 1'b1;
            end else begin
              cy <= cy + 1'b1;
            end
          end else begin
            cx <= cx + 1'b1;
          end
        end
`endif
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule
